// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer, and redirect handling.
// Optional performance counters (fetched_cnt, bubble_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] if_id_instr,
  output logic [31:0] fetched_cnt,
  output logic [31:0] bubble_cnt
`else
  output logic [31:0] if_id_instr
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    SKID  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] drop_addr_r, drop_addr_s;
  logic [31:0] skid_pc_r, skid_pc_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic        if_id_valid_r, if_id_valid_s;
  logic [31:0] if_id_pc_r, if_id_pc_s;
  logic [31:0] if_id_instr_r, if_id_instr_s;
  logic        deliver_s;
  logic        imem_req_r;
  logic [31:0] imem_addr_r;

  // Next-state and datapath selection for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    drop_addr_s   = drop_addr_r;
    skid_pc_s     = skid_pc_r;
    skid_instr_s  = skid_instr_r;
    if_id_valid_s = if_id_valid_r;
    if_id_pc_s    = if_id_pc_r;
    if_id_instr_s = if_id_instr_r;
    deliver_s     = 1'b0;

    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          if_id_valid_s = 1'b0;
          pc_s          = branch_target;
          if (imem_ready) begin
            state_s = FETCH;
          end else begin
            // The outstanding request must complete before the new target is issued.
            drop_addr_s = pc_r;
            state_s     = DROP;
          end
        end else if (imem_ready) begin
          pc_s = pc_r + 32'd4;
          if (stall) begin
            skid_pc_s    = pc_r;
            skid_instr_s = imem_rdata;
            state_s      = SKID;
          end else begin
            if_id_valid_s = 1'b1;
            if_id_pc_s    = pc_r;
            if_id_instr_s = imem_rdata;
            deliver_s     = 1'b1;
          end
        end else begin
          if (!stall) begin
            if_id_valid_s = 1'b0;
          end else begin
            if_id_valid_s = if_id_valid_r;
          end
        end
      end
      SKID: begin
        if (branch_taken) begin
          if_id_valid_s = 1'b0;
          pc_s          = branch_target;
          state_s       = FETCH;
        end else if (!stall) begin
          if_id_valid_s = 1'b1;
          if_id_pc_s    = skid_pc_r;
          if_id_instr_s = skid_instr_r;
          deliver_s     = 1'b1;
          state_s       = FETCH;
        end else begin
          state_s = SKID;
        end
      end
      DROP: begin
        if (branch_taken) begin
          if_id_valid_s = 1'b0;
          pc_s          = branch_target;
        end else if (!stall) begin
          if_id_valid_s = 1'b0;
        end else begin
          if_id_valid_s = if_id_valid_r;
        end
        if (imem_ready) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s       = FETCH;
        if_id_valid_s = 1'b0;
      end
    endcase
  end

  // FSM, PC, skid buffer and IF/ID pipeline registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      drop_addr_r   <= 32'h0000_0000;
      skid_pc_r     <= 32'h0000_0000;
      skid_instr_r  <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      drop_addr_r   <= drop_addr_s;
      skid_pc_r     <= skid_pc_s;
      skid_instr_r  <= skid_instr_s;
      if_id_valid_r <= if_id_valid_s;
      if_id_pc_r    <= if_id_pc_s;
      if_id_instr_r <= if_id_instr_s;
    end
  end

  // Memory request outputs registered from the next state so they stay glitch-free.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      imem_req_r  <= 1'b1;
      imem_addr_r <= RESET_PC;
    end else begin
      imem_req_r  <= (state_s != SKID);
      imem_addr_r <= (state_s == DROP) ? drop_addr_s : pc_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign if_id_valid = if_id_valid_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_instr = if_id_instr_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Delivered-instruction and empty-IF/ID cycle counters, both free-running modulo 2^32.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetched_cnt_r <= 32'h0000_0000;
      bubble_cnt_r  <= 32'h0000_0000;
    end else begin
      if (deliver_s) begin
        fetched_cnt_r <= fetched_cnt_r + 32'd1;
      end else begin
        fetched_cnt_r <= fetched_cnt_r;
      end
      if (!if_id_valid_r) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign fetched_cnt = fetched_cnt_r;
  assign bubble_cnt  = bubble_cnt_r;
`else
  logic unused_deliver_s;
  assign unused_deliver_s = deliver_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, wait states, stall/skid, redirects, wrap and reset.
module tb_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] bubble_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  fetch_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
`ifdef FETCH_PERF_CNT_EN
    .if_id_instr  (if_id_instr),
    .fetched_cnt  (fetched_cnt),
    .bubble_cnt   (bubble_cnt)
`else
    .if_id_instr  (if_id_instr)
`endif
  );

  // Memory model: the word at an address is the address XOR a fixed tag.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset         = 1'b0;
    imem_ready    = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    #12;
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_pc",    if_id_pc,             32'h0000_0000);
    check("rst_instr", if_id_instr,          32'h0000_0000);
    check("rst_req",   {31'd0, imem_req},    32'd1);
    check("rst_addr",  imem_addr,            32'h0000_0000);

    // Streaming fetch with memory always ready.
    @(negedge Clk);
    Reset = 1'b1;
    step;
    check("seq0_addr",  imem_addr,            32'h0000_0004);
    check("seq0_valid", {31'd0, if_id_valid}, 32'd1);
    check("seq0_pc",    if_id_pc,             32'h0000_0000);
    check("seq0_instr", if_id_instr,          32'hA5A5_0000);
    step;
    check("seq1_addr",  imem_addr,   32'h0000_0008);
    check("seq1_pc",    if_id_pc,    32'h0000_0004);
    check("seq1_instr", if_id_instr, 32'hA5A5_0004);
    step;
    step;
    check("seq3_addr", imem_addr, 32'h0000_0010);
    check("seq3_pc",   if_id_pc,  32'h0000_000C);

    // Three wait states at 0x10.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      check("wait_addr",  imem_addr,            32'h0000_0010);
      check("wait_valid", {31'd0, if_id_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    step;
    check("wait_done_valid", {31'd0, if_id_valid}, 32'd1);
    check("wait_done_pc",    if_id_pc,             32'h0000_0010);
    check("wait_done_instr", if_id_instr,          32'hA5A5_0010);

    // Two stall cycles: 0x14 goes to the skid buffer.
    stall = 1'b1;
    step;
    check("stall1_req", {31'd0, imem_req}, 32'd0);
    check("stall1_pc",  if_id_pc,          32'h0000_0010);
    step;
    check("stall2_req",   {31'd0, imem_req},    32'd0);
    check("stall2_pc",    if_id_pc,             32'h0000_0010);
    check("stall2_valid", {31'd0, if_id_valid}, 32'd1);
    stall = 1'b0;
    step;
    check("skid_pc",    if_id_pc,          32'h0000_0014);
    check("skid_instr", if_id_instr,       32'hA5A5_0014);
    check("skid_req",   {31'd0, imem_req}, 32'd1);
    check("skid_addr",  imem_addr,         32'h0000_0018);
    step;
    check("post_skid_pc", if_id_pc, 32'h0000_0018);
    step;
    check("pre_br_addr", imem_addr, 32'h0000_0020);

    // Redirect to 0x100 while 0x20 is still outstanding.
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    step;
    check("drop_addr",  imem_addr,            32'h0000_0020);
    check("drop_valid", {31'd0, if_id_valid}, 32'd0);
    branch_taken = 1'b0;
    step;
    check("drop_hold_addr", imem_addr, 32'h0000_0020);
    imem_ready = 1'b1;
    step;
    check("drop_done_addr",  imem_addr,            32'h0000_0100);
    check("drop_done_valid", {31'd0, if_id_valid}, 32'd0);
    step;
    check("tgt_valid", {31'd0, if_id_valid}, 32'd1);
    check("tgt_pc",    if_id_pc,             32'h0000_0100);
    check("tgt_instr", if_id_instr,          32'hA5A5_0100);

    // Redirect while the returned word is ready: it is discarded.
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    step;
    check("brrdy_valid", {31'd0, if_id_valid}, 32'd0);
    check("brrdy_addr",  imem_addr,            32'h0000_0200);
    branch_taken = 1'b0;
    step;
    check("brrdy_pc", if_id_pc, 32'h0000_0200);

    // Redirect out of SKID, beating stall; target exercises PC wrap.
    stall = 1'b1;
    step;
    check("skid2_req", {31'd0, imem_req}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step;
    check("brskid_valid", {31'd0, if_id_valid}, 32'd0);
    check("brskid_addr",  imem_addr,            32'hFFFF_FFFC);
    check("brskid_req",   {31'd0, imem_req},    32'd1);
    branch_taken = 1'b0;
    stall        = 1'b0;
    step;
    check("wrap_pc",    if_id_pc,    32'hFFFF_FFFC);
    check("wrap_instr", if_id_instr, 32'h5A5A_FFFC);
    check("wrap_addr",  imem_addr,   32'h0000_0000);
    step;
    check("wrap_next_pc", if_id_pc, 32'h0000_0000);

    // Two redirects while dropping: the newer target wins.
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0300;
    step;
    check("ddrop1_addr", imem_addr, 32'h0000_0004);
    branch_target = 32'h0000_0400;
    step;
    check("ddrop2_addr", imem_addr, 32'h0000_0004);
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    step;
    check("ddrop_done_addr", imem_addr, 32'h0000_0400);
    step;
    check("ddrop_pc", if_id_pc, 32'h0000_0400);

    // Asynchronous reset with a request pending.
    imem_ready = 1'b0;
    Reset      = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("mid_rst_pc",    if_id_pc,             32'h0000_0000);
    check("mid_rst_instr", if_id_instr,          32'h0000_0000);
    check("mid_rst_addr",  imem_addr,            32'h0000_0000);
    check("mid_rst_req",   {31'd0, imem_req},    32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fcnt", fetched_cnt, 32'h0000_0000);
    check("mid_rst_bcnt", bubble_cnt,  32'h0000_0000);
`endif
    @(negedge Clk);
    Reset      = 1'b1;
    imem_ready = 1'b1;
    step;
    check("restart_valid", {31'd0, if_id_valid}, 32'd1);
    check("restart_pc",    if_id_pc,             32'h0000_0000);
    check("restart_addr",  imem_addr,            32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
